// File: rtl/cache_bus_arbiter.sv
// N-requester arbiter merging cache/TLB memory requests onto one generic-bus port.
// Round-robin or fixed priority, lock-based bursts bounded by a per-tenure beat guard.
module cache_bus_arbiter #(
  parameter int    NUM_REQ   = 3,
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter string ARB_MODE  = "round_robin",
  parameter int    MAX_BURST = 8,
  localparam int   IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int   BEW       = DATA_W / 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*BEW-1:0]    req_byte_en,
  input  logic [NUM_REQ-1:0]        req_ren,
  input  logic [NUM_REQ-1:0]        req_wen,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [BEW-1:0]            mem_byte_en,
  output logic                      mem_ren,
  output logic                      mem_wen,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_busy,
  output logic                      grant_valid,
  output logic [IDW-1:0]            grant_id
);

  localparam int             CW         = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAX_B      = CW'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);
  localparam bit             FIXED_MODE = (ARB_MODE == "fixed");

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  beat_q, beat_d;

  logic [NUM_REQ-1:0] req_act;
  assign req_act = req_ren | req_wen;

  // Owner's request fields, selected by comparison so an unused id never indexes out of range.
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [BEW-1:0]    own_be;
  logic              own_ren, own_wen, own_lock, own_act;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    own_addr  = '0;
    own_wdata = '0;
    own_be    = '0;
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_lock  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        own_wdata = req_wdata[i*DATA_W +: DATA_W];
        own_be    = req_byte_en[i*BEW +: BEW];
        own_ren   = req_ren[i];
        own_wen   = req_wen[i];
        own_lock  = req_lock[i];
      end
    end
    own_act = own_ren | own_wen;
  end

  // Winner search; scanning downward lets the nearest candidate overwrite farther ones.
  logic           win_found;
  logic [IDW-1:0] win_id;

  always_comb begin
    int unsigned        idx;
    logic [NUM_REQ-1:0] shifted;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    shifted   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (FIXED_MODE) begin
        idx = k;
      end else begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      end
      shifted = req_act >> idx;
      if (shifted[0]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  logic [IDW-1:0] ptr_next;
  logic [CW-1:0]  beat_inc;

  assign ptr_next = FIXED_MODE ? '0 : ((owner_q == LAST_ID) ? '0 : owner_q + 1'b1);
  assign beat_inc = (beat_q >= MAX_B) ? beat_q : beat_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    grant_valid = 1'b0;
    grant_id    = '0;
    req_busy    = '1;
    req_rdata   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_ACTIVE;
          owner_d = win_id;
          beat_d  = '0;
        end
      end

      ST_ACTIVE: begin
        grant_valid = 1'b1;
        grant_id    = owner_q;
        mem_addr    = own_addr;
        mem_wdata   = own_wdata;
        mem_byte_en = own_be;
        mem_wen     = own_wen;
        mem_ren     = own_ren & ~own_wen;
        req_rdata   = mem_rdata;
        // An abandoned beat never reports completion.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == IDW'(i)) req_busy[i] = mem_busy | ~own_act;
        end

        if (!own_act) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          ptr_d   = ptr_next;
        end else if (!mem_busy) begin
          if (own_lock && (beat_inc < MAX_B)) begin
            beat_d = beat_inc;
          end else begin
            state_d = ST_IDLE;
            beat_d  = '0;
            ptr_d   = ptr_next;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: round-robin, fixed-priority and short-guard
// instances share one stimulus stream; each scenario checks the instance it targets.
module tb_cache_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  localparam logic [N*AW-1:0] ADDRS  = {32'h0000_2200, 32'h0000_1100, 32'h0000_0A00};
  localparam logic [N*DW-1:0] WDATAS = {32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
  localparam logic [N*BW-1:0] BES    = {4'hC, 4'h3, 4'hF};

  logic          CLK, nRST;
  logic [N-1:0]  req_ren, req_wen, req_lock;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;

  logic [N-1:0]  rr_busy, fx_busy, g_busy;
  logic [DW-1:0] rr_rdata, fx_rdata, g_rdata;
  logic [AW-1:0] rr_addr, fx_addr, g_addr;
  logic [DW-1:0] rr_wdata, fx_wdata, g_wdata;
  logic [BW-1:0] rr_be, fx_be, g_be;
  logic          rr_ren, fx_ren, g_ren, rr_wen, fx_wen, g_wen;
  logic          rr_gv, fx_gv, g_gv;
  logic [1:0]    rr_gid, fx_gid, g_gid;

  int n_cmp = 0;
  int n_err = 0;

  cache_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("round_robin"), .MAX_BURST(8)) u_rr (
    .CLK(CLK), .nRST(nRST), .req_addr(ADDRS), .req_wdata(WDATAS), .req_byte_en(BES),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock), .req_busy(rr_busy), .req_rdata(rr_rdata),
    .mem_addr(rr_addr), .mem_wdata(rr_wdata), .mem_byte_en(rr_be), .mem_ren(rr_ren), .mem_wen(rr_wen),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_valid(rr_gv), .grant_id(rr_gid));

  cache_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("fixed"), .MAX_BURST(8)) u_fx (
    .CLK(CLK), .nRST(nRST), .req_addr(ADDRS), .req_wdata(WDATAS), .req_byte_en(BES),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock), .req_busy(fx_busy), .req_rdata(fx_rdata),
    .mem_addr(fx_addr), .mem_wdata(fx_wdata), .mem_byte_en(fx_be), .mem_ren(fx_ren), .mem_wen(fx_wen),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_valid(fx_gv), .grant_id(fx_gid));

  cache_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("round_robin"), .MAX_BURST(4)) u_g (
    .CLK(CLK), .nRST(nRST), .req_addr(ADDRS), .req_wdata(WDATAS), .req_byte_en(BES),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock), .req_busy(g_busy), .req_rdata(g_rdata),
    .mem_addr(g_addr), .mem_wdata(g_wdata), .mem_byte_en(g_be), .mem_ren(g_ren), .mem_wen(g_wen),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_valid(g_gv), .grant_id(g_gid));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return ADDRS[i*AW +: AW];
  endfunction

  function automatic logic [2:0] busy_low(input int i);
    return 3'b111 & ~(3'b001 << i);
  endfunction

  // Two reset edges with all requests idle; returns at a negedge with nRST released.
  task automatic do_reset();
    nRST = 1'b0; req_ren = '0; req_wen = '0; req_lock = '0; mem_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id;
    nRST = 1'b0; req_ren = 3'b111; req_wen = '0; req_lock = '0;
    mem_busy = 1'b1; mem_rdata = 32'h1234_5678;

    // Reset held two cycles with every requester reading.
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #1;
      check("rst_mem_ren", 32'(rr_ren), 32'd0);
      check("rst_gv", 32'(rr_gv), 32'd0);
      check("rst_busy", 32'(rr_busy), 32'b111);
      check("rst_rdata", rr_rdata, 32'd0);
      check("rst_addr", rr_addr, 32'd0);
    end
    nRST = 1'b1;
    @(negedge CLK);

    // Round-robin fairness: two-cycle beats, one idle cycle between tenures.
    for (int t = 0; t < 6; t++) begin
      id = t % 3;
      mem_busy = 1'b1; #1;
      check("rr_gid", 32'(rr_gid), 32'(id));
      check("rr_gv", 32'(rr_gv), 32'd1);
      check("rr_busy_wait", 32'(rr_busy), 32'b111);
      check("rr_addr", rr_addr, addr_of(id));
      check("rr_mem_ren", 32'(rr_ren), 32'd1);
      @(negedge CLK);
      mem_busy = 1'b0; mem_rdata = 32'hAB00_0000 | 32'(t); #1;
      check("rr_busy_done", 32'(rr_busy), 32'(busy_low(id)));
      check("rr_rdata", rr_rdata, 32'hAB00_0000 | 32'(t));
      @(negedge CLK);
      #1;
      check("rr_idle_gv", 32'(rr_gv), 32'd0);
      check("rr_idle_busy", 32'(rr_busy), 32'b111);
      @(negedge CLK);
    end

    // Fixed priority: requester 0 arrives mid-tenure of 2 and then keeps winning.
    do_reset();
    req_ren = 3'b100; mem_busy = 1'b1; #1;
    check("fx_idle_gv", 32'(fx_gv), 32'd0);
    @(negedge CLK); #1;
    check("fx_gid_2", 32'(fx_gid), 32'd2);
    check("fx_addr_2", fx_addr, addr_of(2));
    @(negedge CLK);
    req_ren = 3'b101; #1;
    check("fx_gid_2_hold", 32'(fx_gid), 32'd2);
    check("fx_busy_wait", 32'(fx_busy), 32'b111);
    @(negedge CLK);
    mem_busy = 1'b0; #1;
    check("fx_busy_done2", 32'(fx_busy), 32'b011);
    @(negedge CLK); #1;
    check("fx_idle1", 32'(fx_gv), 32'd0);
    @(negedge CLK);
    mem_busy = 1'b1; #1;
    check("fx_gid_0", 32'(fx_gid), 32'd0);
    check("fx_addr_0", fx_addr, addr_of(0));
    @(negedge CLK);
    mem_busy = 1'b0; #1;
    check("fx_busy_done0", 32'(fx_busy), 32'b110);
    @(negedge CLK); #1;
    check("fx_idle2", 32'(fx_gv), 32'd0);
    @(negedge CLK);
    mem_busy = 1'b1; #1;
    check("fx_gid_0_again", 32'(fx_gid), 32'd0);
    check("rr_gid_rotates", 32'(rr_gid), 32'd2);

    // Locked burst of four beats on the D$ channel, then rotation to 2.
    do_reset();
    req_ren = 3'b010; req_lock = 3'b010; mem_busy = 1'b0; #1;
    check("lk_idle_gv", 32'(rr_gv), 32'd0);
    @(negedge CLK);
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) req_lock = 3'b000;
      #1;
      check("lk_gv", 32'(rr_gv), 32'd1);
      check("lk_gid", 32'(rr_gid), 32'd1);
      check("lk_busy", 32'(rr_busy), 32'b101);
      @(negedge CLK);
    end
    req_ren = 3'b111; mem_busy = 1'b1; #1;
    check("lk_release", 32'(rr_gv), 32'd0);
    @(negedge CLK); #1;
    check("lk_ptr_2", 32'(rr_gid), 32'd2);

    // Burst guard: MAX_BURST=4 forces hand-off despite a permanent lock.
    do_reset();
    req_ren = 3'b110; req_lock = 3'b010; mem_busy = 1'b0; #1;
    check("gd_idle_gv", 32'(g_gv), 32'd0);
    @(negedge CLK);
    for (int b = 1; b <= 4; b++) begin
      #1;
      check("gd_gid_1", 32'(g_gid), 32'd1);
      check("gd_gv", 32'(g_gv), 32'd1);
      check("gd_busy", 32'(g_busy), 32'b101);
      @(negedge CLK);
    end
    #1;
    check("gd_forced_idle", 32'(g_gv), 32'd0);
    check("gd_rr8_still_1", 32'(rr_gid), 32'd1);
    check("gd_rr8_gv", 32'(rr_gv), 32'd1);
    @(negedge CLK);
    mem_busy = 1'b1; #1;
    check("gd_gid_2", 32'(g_gid), 32'd2);
    check("gd_busy_2", 32'(g_busy), 32'b111);

    // Abort: owner drops its read while memory is still busy.
    do_reset();
    req_ren = 3'b001; mem_busy = 1'b1;
    @(negedge CLK); #1;
    check("ab_mem_ren_on", 32'(rr_ren), 32'd1);
    @(negedge CLK);
    req_ren = 3'b000; #1;
    check("ab_mem_ren_off", 32'(rr_ren), 32'd0);
    check("ab_no_pulse", 32'(rr_busy), 32'b111);
    @(negedge CLK);
    req_ren = 3'b111; #1;
    check("ab_idle", 32'(rr_gv), 32'd0);
    @(negedge CLK); #1;
    check("ab_ptr_1", 32'(rr_gid), 32'd1);

    // Read and write together forward as a write; reset aborts the tenure.
    do_reset();
    req_ren = 3'b100; req_wen = 3'b100; mem_busy = 1'b1;
    @(negedge CLK); #1;
    check("rw_wen", 32'(rr_wen), 32'd1);
    check("rw_ren", 32'(rr_ren), 32'd0);
    check("rw_wdata", rr_wdata, 32'hD2D2_0002);
    check("rw_be", 32'(rr_be), 32'hC);
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK); #1;
    check("rst_mid_gv", 32'(rr_gv), 32'd0);
    check("rst_mid_wen", 32'(rr_wen), 32'd0);
    check("rst_mid_busy", 32'(rr_busy), 32'b111);
    nRST = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
